// File: rtl/workout_pkg.sv
// Shared workout types: sequencer phase encoding and default widths.
package workout_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_WORKOUT = 2'b01,
    PH_REST    = 2'b10,
    PH_FINISH  = 2'b11
  } phase_t;

  localparam int W_DEF = 8;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle tick per second.
module sec_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/phase_timer.sv
// Per-phase countdown: reloads on sequencer phase entry, counts down
// whole seconds, and holds time_done until the next phase change.
module phase_timer
  import workout_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int W        = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  phase_t       phase,
  input  logic [W-1:0] work_sec,
  input  logic [W-1:0] rest_sec,
  input  logic         pause,
  input  logic         skip,
  output logic [W-1:0] remaining,
  output logic         time_done,
  output logic         running,
  output logic         paused,
  output logic         sec_tick
);

  typedef enum logic [1:0] {
    T_STOP,
    T_RUN,
    T_PAUSED,
    T_EXPIRED
  } tstate_t;

  tstate_t      state, state_n;
  phase_t       prev_phase;
  logic [W-1:0] rem_n;
  logic         tick_n;
  logic         load;
  logic         active;
  logic         do_skip;
  logic         pre_clear;
  logic         pre_en;
  logic         tick;

  assign load    = (phase != prev_phase);
  assign active  = (state == T_RUN) || (state == T_PAUSED);
  assign do_skip = skip && (phase == PH_WORKOUT);

  // Enables only depend on registered state and inputs, never on tick.
  assign pre_clear = reset || load;
  assign pre_en    = active && !do_skip && !pause;

  sec_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .clear (pre_clear),
    .enable(pre_en),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    rem_n   = remaining;
    tick_n  = 1'b0;
    if (load) begin
      unique case (phase)
        PH_WORKOUT: begin
          rem_n   = work_sec;
          state_n = (work_sec == '0) ? T_EXPIRED : T_RUN;
        end
        PH_REST: begin
          rem_n   = rest_sec;
          state_n = (rest_sec == '0) ? T_EXPIRED : T_RUN;
        end
        default: begin
          rem_n   = '0;
          state_n = T_STOP;
        end
      endcase
    end else if (active) begin
      if (do_skip) begin
        rem_n   = '0;
        state_n = T_EXPIRED;
      end else if (pause) begin
        state_n = T_PAUSED;
      end else begin
        state_n = T_RUN;
        if (tick && remaining != '0) begin
          rem_n  = remaining - 1'b1;
          tick_n = 1'b1;
          if (remaining == W'(1))
            state_n = T_EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= T_STOP;
      prev_phase <= PH_IDLE;
      remaining  <= '0;
      sec_tick   <= 1'b0;
    end else begin
      state      <= state_n;
      prev_phase <= phase;
      remaining  <= rem_n;
      sec_tick   <= tick_n;
    end
  end

  assign time_done = (state == T_EXPIRED);
  assign running   = (state == T_RUN);
  assign paused    = (state == T_PAUSED);

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: directed scenarios then random
// traffic, checked against a second-counting reference model.
module tb_phase_timer;
  import workout_pkg::*;

  localparam int TD = 4;
  localparam int W  = 8;

  typedef struct packed {
    logic [W-1:0] rem;
    logic         done;
    logic         run;
    logic         pau;
    logic         tick;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  phase_t       phase;
  logic [W-1:0] work_sec, rest_sec;
  logic         pause, skip;
  logic [W-1:0] remaining;
  logic         time_done, running, paused, sec_tick;

  logic         n_reset = 1'b1;
  phase_t       n_phase = PH_IDLE;
  logic [W-1:0] n_work  = '0;
  logic [W-1:0] n_rest  = '0;
  logic         n_pause = 1'b0;
  logic         n_skip  = 1'b0;

  int checks = 0;
  int fails  = 0;
  exp_t sb[$];

  // Reference model state: seconds left, cycles counted into the
  // current second, whether a countdown is live.
  phase_t m_prev = PH_IDLE;
  int     m_rem = 0, m_cyc = 0;
  bit     m_live = 0, m_done = 0, m_run = 0, m_pau = 0, m_tick = 0;

  phase_timer #(.TICK_DIV(TD), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .phase    (phase),
    .work_sec (work_sec),
    .rest_sec (rest_sec),
    .pause    (pause),
    .skip     (skip),
    .remaining(remaining),
    .time_done(time_done),
    .running  (running),
    .paused   (paused),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic model();
    int n;
    m_tick = 0;
    if (reset) begin
      m_prev = PH_IDLE; m_rem = 0; m_cyc = 0;
      m_live = 0; m_done = 0; m_run = 0; m_pau = 0;
    end else if (phase != m_prev) begin
      m_prev = phase; m_pau = 0; m_cyc = 0;
      if (phase == PH_WORKOUT || phase == PH_REST) begin
        n = (phase == PH_WORKOUT) ? int'(work_sec) : int'(rest_sec);
        m_rem = n; m_done = (n == 0); m_live = (n != 0); m_run = m_live;
      end else begin
        m_rem = 0; m_done = 0; m_live = 0; m_run = 0;
      end
    end else if (m_live) begin
      if (skip && phase == PH_WORKOUT) begin
        m_rem = 0; m_done = 1; m_live = 0; m_run = 0; m_pau = 0;
      end else if (pause) begin
        m_pau = 1; m_run = 0;
      end else begin
        m_pau = 0; m_run = 1; m_cyc++;
        if (m_cyc == TD) begin
          m_cyc = 0; m_rem--; m_tick = 1;
          if (m_rem == 0) begin
            m_done = 1; m_live = 0; m_run = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input int cycles);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset = n_reset; phase = n_phase;
      work_sec = n_work; rest_sec = n_rest;
      pause = n_pause; skip = n_skip;
      model();
      e.rem = W'(m_rem); e.done = m_done; e.run = m_run;
      e.pau = m_pau; e.tick = m_tick;
      sb.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents a fresh output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("remaining", int'(remaining), int'(e.rem));
        chk("time_done", int'(time_done), int'(e.done));
        chk("running",   int'(running),   int'(e.run));
        chk("paused",    int'(paused),    int'(e.pau));
        chk("sec_tick",  int'(sec_tick),  int'(e.tick));
      end
    end
  end

  initial begin
    step(3);
    n_reset = 0; step(2);
    // nominal workout
    n_work = 3; n_phase = PH_WORKOUT; step(16);
    n_phase = PH_IDLE; step(1);
    // pause for 6 edges from k+2
    n_phase = PH_WORKOUT; step(2);
    n_pause = 1; step(6);
    n_pause = 0; step(14);
    // skip in workout at remaining 5
    n_phase = PH_IDLE; n_work = 9; step(1);
    n_phase = PH_WORKOUT; step(1 + 4 * TD);
    n_skip = 1; step(1);
    n_skip = 0; step(2);
    // skip ignored during rest
    n_rest = 9; n_phase = PH_REST; step(5);
    n_skip = 1; step(2);
    n_skip = 0; step(2);
    // zero rest, then phase change out of expiry
    n_work = 5; n_phase = PH_WORKOUT; step(3);
    n_rest = 0; n_phase = PH_REST; step(3);
    n_work = 7; n_phase = PH_WORKOUT; step(3);
    // reset mid-run at remaining 2
    n_phase = PH_IDLE; n_work = 3; step(1);
    n_phase = PH_WORKOUT; step(TD + 1);
    n_work = 9; n_reset = 1; step(1);
    n_reset = 0; step(3);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      n_reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0)
        n_phase = phase_t'($urandom_range(0, 3));
      n_work  = W'($urandom_range(0, 5));
      n_rest  = W'($urandom_range(0, 4));
      n_pause = ($urandom_range(0, 4) == 0);
      n_skip  = ($urandom_range(0, 19) == 0);
      step($urandom_range(1, 12));
    end
    n_reset = 0; n_pause = 0; n_skip = 0; step(2);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
